// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, controller states and datapath width.
package alu_pkg;
  localparam int DEF_DATA_W = 16;
  typedef enum logic [3:0] {
    ADD, SUB, OR, AND, XOR, NOR, NAND, XNOR,
    SHL, SHR, ASHL, ASHR, NOTB, RSUB
  } alu_op_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  function automatic logic is_arith(input logic [3:0] op);
    return op == ADD || op == SUB || op == RSUB;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DATA_W register file, two async read ports, one sync write port, R0 reads zero.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG = 8,
  parameter int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] mem [NREG];
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    else if (we && waddr != '0)
      mem[waddr] <= wdata;
  assign rdata_a = raddr_a == '0 ? '0 : mem[raddr_a];
  assign rdata_b = raddr_b == '0 ? '0 : mem[raddr_b];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction per three cycles to the ALU, then writes back result and flags.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREG = 8,
  parameter int AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid_in,
  output logic              instr_ready_out,
  input  logic [3:0]        opcode_in,
  input  logic [AW-1:0]     rd_in,
  input  logic [AW-1:0]     rs1_in,
  input  logic [AW-1:0]     rs2_in,
  input  logic              imm_valid_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic              use_carry_in,
  output logic              alu_enable_out,
  output logic [3:0]        alu_sel_out,
  output logic [DATA_W-1:0] alu_a_out,
  output logic [DATA_W-1:0] alu_b_out,
  output logic              alu_cin_out,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic              alu_cout_in,
  output logic              wb_valid_out,
  output logic [AW-1:0]     wb_addr_out,
  output logic [DATA_W-1:0] wb_data_out,
  output logic              carry_flag_out,
  output logic              zero_flag_out
);
  state_t state, state_n;
  logic [AW-1:0] rd_q;
  logic cout_q;
  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic accept;
  alu_regfile #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) u_rf (
    .clk(clk), .rst(rst),
    .we(wb_valid_out), .waddr(wb_addr_out), .wdata(wb_data_out),
    .raddr_a(rs1_in), .rdata_a(rdata_a),
    .raddr_b(rs2_in), .rdata_b(rdata_b)
  );
  always_comb begin
    instr_ready_out = state == IDLE;
    alu_enable_out = state == EXEC;
    wb_valid_out = state == WB;
    accept = instr_valid_in && instr_ready_out;
    state_n = state == IDLE ? (accept ? EXEC : IDLE) : state == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      rd_q <= '0;
      cout_q <= 1'b0;
      alu_sel_out <= '0;
      alu_a_out <= '0;
      alu_b_out <= '0;
      alu_cin_out <= 1'b0;
      wb_addr_out <= '0;
      wb_data_out <= '0;
      carry_flag_out <= 1'b0;
      zero_flag_out <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        alu_sel_out <= opcode_in;
        rd_q <= rd_in;
        alu_a_out <= rdata_a;
        alu_b_out <= imm_valid_in ? imm_in : rdata_b;
        alu_cin_out <= use_carry_in & carry_flag_out;
      end
      if (state == EXEC) begin
        wb_data_out <= alu_res_in;
        cout_q <= alu_cout_in;
        wb_addr_out <= rd_q;
      end
      // alu_sel_out still holds the writeback instruction's opcode here
      if (state == WB) begin
        zero_flag_out <= wb_data_out == '0;
        if (is_arith(alu_sel_out)) carry_flag_out <= cout_q;
      end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions checked against an architectural register/flag model.
module tb_alu_issue_ctrl;
  logic clk = 0, rst = 1;
  logic instr_valid_in = 0, instr_ready_out;
  logic [3:0] opcode_in = 0;
  logic [2:0] rd_in = 0, rs1_in = 0, rs2_in = 0;
  logic imm_valid_in = 0, use_carry_in = 0;
  logic [15:0] imm_in = 0;
  logic alu_enable_out, alu_cin_out, alu_cout_in, wb_valid_out, carry_flag_out, zero_flag_out;
  logic [3:0] alu_sel_out;
  logic [15:0] alu_a_out, alu_b_out, alu_res_in, wb_data_out;
  logic [2:0] wb_addr_out;
  int errors = 0, checks = 0, wb_cnt = 0;
  logic [15:0] rf [8];
  logic carry_m = 0, zero_m = 0;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
    .opcode_in(opcode_in), .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in),
    .imm_valid_in(imm_valid_in), .imm_in(imm_in), .use_carry_in(use_carry_in),
    .alu_enable_out(alu_enable_out), .alu_sel_out(alu_sel_out), .alu_a_out(alu_a_out),
    .alu_b_out(alu_b_out), .alu_cin_out(alu_cin_out), .alu_res_in(alu_res_in),
    .alu_cout_in(alu_cout_in), .wb_valid_out(wb_valid_out), .wb_addr_out(wb_addr_out),
    .wb_data_out(wb_data_out), .carry_flag_out(carry_flag_out), .zero_flag_out(zero_flag_out)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] alu_f(input logic [3:0] op, input logic [15:0] a, b, input logic cin);
    case (op)
      4'd0:  return {1'b0, a} + {1'b0, b} + 17'(cin);
      4'd1:  return {1'b0, a} - {1'b0, b} - 17'(cin);
      4'd2:  return {1'b0, a | b};
      4'd3:  return {1'b0, a & b};
      4'd4:  return {1'b0, a ^ b};
      4'd5:  return {1'b0, ~(a | b)};
      4'd6:  return {1'b0, ~(a & b)};
      4'd7:  return {1'b0, ~(a ^ b)};
      4'd8:  return {1'b0, a << b[3:0]};
      4'd9:  return {1'b0, a >> b[3:0]};
      4'd10: return {1'b0, a <<< b[3:0]};
      4'd11: return {1'b0, 16'($signed(a) >>> b[3:0])};
      4'd12: return {1'b0, ~b};
      4'd13: return {1'b0, b} - {1'b0, a} - 17'(cin);
      default: return {1'b0, a};
    endcase
  endfunction

  // the bench plays the ALU on the far side of the interface
  always_comb {alu_cout_in, alu_res_in} = alu_f(alu_sel_out, alu_a_out, alu_b_out, alu_cin_out);

  always @(negedge clk) if (wb_valid_out) wb_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready", 32'(instr_ready_out), 1);
    chk("rst_en", 32'(alu_enable_out), 0);
    chk("rst_sel", 32'(alu_sel_out), 0);
    chk("rst_a", 32'(alu_a_out), 0);
    chk("rst_b", 32'(alu_b_out), 0);
    chk("rst_cin", 32'(alu_cin_out), 0);
    chk("rst_wbv", 32'(wb_valid_out), 0);
    chk("rst_wba", 32'(wb_addr_out), 0);
    chk("rst_wbd", 32'(wb_data_out), 0);
    chk("rst_carry", 32'(carry_flag_out), 0);
    chk("rst_zero", 32'(zero_flag_out), 0);
  endtask

  task automatic model_reset();
    foreach (rf[i]) rf[i] = '0;
    carry_m = 0;
    zero_m = 0;
  endtask

  // called #1 after a posedge with the DUT idle; leaves the DUT idle #1 after the writeback edge
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, input logic immv,
                       input logic [15:0] imm, input logic uc, input logic hold);
    logic [15:0] ea, eb, eres;
    logic ecin, ecout;
    int wb0;
    ea = rf[rs1];
    eb = immv ? imm : rf[rs2];
    ecin = uc & carry_m;
    {ecout, eres} = alu_f(op, ea, eb, ecin);
    instr_valid_in = 1; opcode_in = op; rd_in = rd; rs1_in = rs1; rs2_in = rs2;
    imm_valid_in = immv; imm_in = imm; use_carry_in = uc;
    chk("idle_ready", 32'(instr_ready_out), 1);
    wb0 = wb_cnt;
    @(posedge clk); #1;
    if (!hold) instr_valid_in = 0;
    chk("ex_en", 32'(alu_enable_out), 1);
    chk("ex_ready", 32'(instr_ready_out), 0);
    chk("ex_sel", 32'(alu_sel_out), 32'(op));
    chk("ex_a", 32'(alu_a_out), 32'(ea));
    chk("ex_b", 32'(alu_b_out), 32'(eb));
    chk("ex_cin", 32'(alu_cin_out), 32'(ecin));
    chk("ex_wbv", 32'(wb_valid_out), 0);
    @(posedge clk); #1;
    chk("wb_valid", 32'(wb_valid_out), 1);
    chk("wb_ready", 32'(instr_ready_out), 0);
    chk("wb_en", 32'(alu_enable_out), 0);
    chk("wb_addr", 32'(wb_addr_out), 32'(rd));
    chk("wb_data", 32'(wb_data_out), 32'(eres));
    chk("wb_sel_hold", 32'(alu_sel_out), 32'(op));
    if (rd != 0) rf[rd] = eres;
    zero_m = eres == 0;
    if (op == 4'd0 || op == 4'd1 || op == 4'd13) carry_m = ecout;
    @(posedge clk); #1;
    chk("post_wbv", 32'(wb_valid_out), 0);
    chk("post_wbcnt", wb_cnt - wb0, 1);
    chk("post_carry", 32'(carry_flag_out), 32'(carry_m));
    chk("post_zero", 32'(zero_flag_out), 32'(zero_m));
    chk("post_wbd_hold", 32'(wb_data_out), 32'(eres));
  endtask

  initial begin
    model_reset();
    #12;
    chk_reset_outs();
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    // ADD immediate into r1
    issue(4'd0, 3'd1, 3'd0, 3'd0, 1, 16'h1234, 0, 0);
    chk("add_imm_r1", 32'(rf[1]), 32'h1234);
    // carry chain
    issue(4'd2, 3'd1, 3'd0, 3'd0, 1, 16'hFFFF, 0, 0);
    issue(4'd2, 3'd2, 3'd0, 3'd0, 1, 16'h0001, 0, 0);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 16'h0, 0, 0);
    chk("chain_carry", 32'(carry_m), 1);
    issue(4'd0, 3'd4, 3'd0, 3'd0, 1, 16'h0, 1, 0);
    chk("chain_r4", 32'(rf[4]), 1);
    // flag hold: XOR leaves carry alone
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 16'h0, 0, 0);
    issue(4'd4, 3'd5, 3'd1, 3'd1, 0, 16'h0, 0, 0);
    chk("hold_carry", 32'(carry_flag_out), 1);
    // valid held high back-to-back
    issue(4'd1, 3'd6, 3'd1, 3'd2, 0, 16'h0, 0, 1);
    issue(4'd13, 3'd7, 3'd2, 3'd1, 0, 16'h0, 1, 1);
    issue(4'd8, 3'd5, 3'd2, 3'd0, 1, 16'h0004, 0, 0);
    // R0 stays zero
    issue(4'd2, 3'd0, 3'd0, 3'd0, 1, 16'h5555, 0, 0);
    issue(4'd2, 3'd6, 3'd0, 3'd0, 0, 16'h0, 0, 0);
    for (int k = 0; k < 40; k++)
      issue(4'($urandom_range(15)), 3'($urandom_range(7)), 3'($urandom_range(7)), 3'($urandom_range(7)),
            1'($urandom_range(1)), 16'($urandom), 1'($urandom_range(1)), 0);
    // reset asserted mid-cycle during EXEC drops the instruction
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 16'h0, 0, 0);
    issue(4'd2, 3'd1, 3'd0, 3'd0, 1, 16'hFFFF, 0, 0);
    instr_valid_in = 1; opcode_in = 4'd2; rd_in = 3'd2; rs1_in = 3'd1; imm_valid_in = 1; imm_in = 16'h00F0;
    @(posedge clk); #1;
    instr_valid_in = 0;
    chk("pre_rst_en", 32'(alu_enable_out), 1);
    #2 rst = 1;
    #1 chk_reset_outs();
    model_reset();
    @(posedge clk); #1;
    chk("rst_hold_wbv", 32'(wb_valid_out), 0);
    rst = 0;
    @(posedge clk); #1;
    chk("after_rst_wbv", 32'(wb_valid_out), 0);
    chk("after_rst_ready", 32'(instr_ready_out), 1);
    issue(4'd0, 3'd3, 3'd1, 3'd2, 0, 16'h0, 1, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/writeback controller that drives the 16-bit ALU from the initiator side of its operand/result interface.
- Accepts one decoded instruction per valid/ready handshake.
- Reads operands from an internal 8x16 register file.
- Drives the ALU enable, select, operand and carry-in lines for one cycle, then captures the result and carry-out.
- Writes the result back and maintains carry and zero flags.

Parameters:
DATA_W, 16, datapath width; must match the ALU width.
NREG, 8, register count; address width is clog2(NREG). R0 is hardwired to zero.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
instr_valid_in  input  1  instruction present
instr_ready_out  output  1  controller can accept
opcode_in  input  4  ALU select code, passed through unchanged
rd_in  input  3  destination register
rs1_in  input  3  source A register
rs2_in  input  3  source B register
imm_valid_in  input  1  use imm_in as B instead of rs2
imm_in  input  DATA_W  immediate B operand
use_carry_in  input  1  feed carry flag into ALU carry-in
alu_enable_out  output  1  ALU enable
alu_sel_out  output  4  ALU select
alu_a_out  output  DATA_W  ALU operand A
alu_b_out  output  DATA_W  ALU operand B
alu_cin_out  output  1  ALU carry-in
alu_res_in  input  DATA_W  ALU result
alu_cout_in  input  1  ALU carry-out
wb_valid_out  output  1  one-cycle writeback strobe
wb_addr_out  output  3  writeback register
wb_data_out  output  DATA_W  writeback data
carry_flag_out  output  1  carry flag
zero_flag_out  output  1  zero flag

Behaviour:
- Reset (async, active-high): FSM goes to IDLE; all register-file entries, flags and operand registers clear to 0.
  - Outputs in reset: instr_ready_out=1 and every other output = 0.
  - An in-flight instruction is dropped: no wb_valid_out, no flag change.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready_out=1.
  - On instr_valid_in & instr_ready_out (accept, cycle N), register the following:
    - opcode, rd
    - A = RF[rs1]
    - B = imm_valid_in ? imm_in : RF[rs2]
    - cin = use_carry_in & carry_flag
  - Then go to EXEC. Register reads are combinational from the current RF contents.
- EXEC (cycle N+1):
  - alu_enable_out=1; alu_sel/a/b/cin are driven from the registered values.
  - alu_res_in and alu_cout_in are sampled at the end of the cycle.
  - Go to WB.
- WB (cycle N+2):
  - wb_valid_out=1, wb_addr_out=rd, wb_data_out=captured result.
  - RF[rd] is written at the end of the cycle, unless rd=0; the strobe still pulses for rd=0.
  - zero_flag updates to (result==0) for every opcode.
  - carry_flag updates to the captured carry only for opcodes 0000, 0001 and 1101. For all other opcodes it holds.
  - Flag outputs are registered and visible from N+3. Go to IDLE.
- Handshake:
  - instr_ready_out is low in EXEC and WB.
  - A valid held across those cycles is not accepted until IDLE. The next accept can happen no earlier than N+3, so throughput is 1 instruction per 3 cycles.
  - Because writeback completes before the next read, there is no read-after-write hazard.
- Outside EXEC: alu_enable_out=0. alu_sel/a/b/cin hold their last registered values.
- Outside WB: wb_valid_out=0. wb_addr_out and wb_data_out hold their values.
- Opcodes 1110 and 1111 pass through unchanged; the ALU handles them as its default case.
- The controller performs no arithmetic of its own. Widths are exact, with no extension.

Decomposition:
- Shared package alu_pkg contains:
  - alu_op_t enum for the 4-bit codes: ADD, SUB, OR, AND, XOR, NOR, NAND, XNOR, SHL, SHR, ASHL, ASHR, NOTB, RSUB.
  - is_arith() function returning true for ADD, SUB, RSUB.
  - The FSM state enum.
  - DATA_W default.
- One sub-module: alu_regfile, with NREG x DATA_W entries, 2 combinational read ports, 1 synchronous write port, R0 reads zero, and async clear on rst.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately, instr_ready_out=1; after release, RF reads 0.
- ADD immediate: opcode 0000, rs1=0, imm 0x1234, rd=1, accept at N -> EXEC at N+1 (a=0x0000, b=0x1234); wb_valid at N+2 with addr 1, data 0x1234; zero=0, carry=0.
- Carry chain:
  - r1=0xFFFF, r2=0x0001; ADD rd=3 -> data 0x0000, carry=1, zero=1.
  - Then ADD use_carry, rs1=0, imm 0, rd=4 -> alu_cin_out=1, data 0x0001, carry=0, zero=0.
- Flag hold: after carry=1, XOR r1^r1 -> data 0x0000, zero=1, carry stays 1.
- Backpressure: instr_valid_in held high continuously -> accepts at N, N+3, N+6; instr_ready_out low at N+1 and N+2; exactly one wb_valid pulse per instruction.
- R0 write and mid-op reset:
  - Write 0x5555 to rd=0 -> wb_valid pulses, and a later read of r0 gives 0.
  - Assert rst during EXEC -> no wb_valid, flags 0, ready=1.
